// File: rtl/mul_seq_controller.sv
// One-hot sequence controller for a shift-add multiplier with start/done handshake and an
// iteration counter. Define MUL_EARLY_EXIT_EN to let S_CHECK exit early on a zero operand.
module mul_seq_controller #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SC_W  = 4
) (
    input  logic            clk,
    input  logic            resest,
    input  logic            start,
    input  logic            qa_zero,
    input  logic            qb_zero,
    input  logic            q0,
    output logic [6:0]      y,
    output logic            ld,
    output logic            add_en,
    output logic            shift_en,
    output logic            busy,
    output logic            done,
    output logic [SC_W-1:0] sc
);

    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_LOAD  = 7'b0000010,
        S_CHECK = 7'b0000100,
        S_TEST  = 7'b0001000,
        S_ADD   = 7'b0010000,
        S_SHIFT = 7'b0100000,
        S_DONE  = 7'b1000000
    } state_e;

    logic [6:0]      state_q;
    logic [SC_W-1:0] sc_q;

`ifndef MUL_EARLY_EXIT_EN
    logic unused_zero;
    assign unused_zero = qa_zero ^ qb_zero;
`endif

    always_ff @(posedge clk or negedge resest) begin
        if (!resest) begin
            state_q <= S_IDLE;
            sc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    sc_q    <= SC_W'(WIDTH);
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (qa_zero | qb_zero) state_q <= S_DONE;
                    else                   state_q <= S_TEST;
`else
                    state_q <= S_TEST;
`endif
                end
                S_TEST: begin
                    state_q <= q0 ? S_ADD : S_SHIFT;
                end
                S_ADD: begin
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Saturate at zero; the decrement from 1 is the exit to S_DONE.
                    sc_q    <= (sc_q != '0) ? sc_q - SC_W'(1) : '0;
                    state_q <= (sc_q <= SC_W'(1)) ? S_DONE : S_TEST;
                end
                S_DONE: begin
                    // Early exit leaves sc at WIDTH; clear it on the way back to idle.
                    sc_q    <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    sc_q    <= '0;
                end
            endcase
        end
    end

    assign y        = state_q;
    assign ld       = (state_q == S_LOAD);
    assign add_en   = (state_q == S_ADD);
    assign shift_en = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign sc       = sc_q;

endmodule

// File: tb/tb_mul_seq_controller.sv
// Directed bench for mul_seq_controller (WIDTH=8); follows MUL_EARLY_EXIT_EN if defined.
module tb_mul_seq_controller;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SC_W  = 4;

    localparam logic [6:0] Y_IDLE = 7'b0000001;
    localparam logic [6:0] Y_LOAD = 7'b0000010;
    localparam logic [6:0] Y_TEST = 7'b0001000;

    logic            clk;
    logic            resest;
    logic            start;
    logic            qa_zero;
    logic            qb_zero;
    logic            q0;
    logic [6:0]      y;
    logic            ld;
    logic            add_en;
    logic            shift_en;
    logic            busy;
    logic            done;
    logic [SC_W-1:0] sc;

    int n_checks;
    int n_fail;

    mul_seq_controller #(
        .WIDTH (WIDTH),
        .SC_W  (SC_W)
    ) dut (
        .clk      (clk),
        .resest   (resest),
        .start    (start),
        .qa_zero  (qa_zero),
        .qb_zero  (qb_zero),
        .q0       (q0),
        .y        (y),
        .ld       (ld),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .sc       (sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to done; q0 tracks the multiplier LSB as it shifts.
    task automatic run_op(input string tag, input logic [7:0] mult, input logic za,
                          input logic zb, input int exp_edges, input int exp_adds,
                          input int exp_shifts, input int exp_sc_done);
        int   edges;
        int   adds;
        int   shifts;
        int   idx;
        int   sc_bad;
        int   adjacency_bad;
        logic prev_add;
        logic got_done;
        edges = 0; adds = 0; shifts = 0; idx = 0; sc_bad = 0; adjacency_bad = 0;
        prev_add = 1'b0; got_done = 1'b0;
        @(negedge clk);
        start = 1'b1; qa_zero = za; qb_zero = zb; q0 = mult[0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 60 && !got_done; e++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (prev_add && !shift_en) adjacency_bad++;
            prev_add = add_en;
            if (add_en) adds++;
            if (shift_en) begin
                shifts++;
                idx++;
            end
            if (y == Y_TEST && int'(sc) != WIDTH - idx) sc_bad++;
            q0 = (idx < 8) ? mult[idx] : 1'b0;
            if (done) begin
                got_done = 1'b1;
                check_value({tag, "_sc_at_done"}, sc, exp_sc_done);
            end
        end
        check_value({tag, "_done_seen"}, got_done, 1);
        check_value({tag, "_edges"}, edges, exp_edges);
        check_value({tag, "_adds"}, adds, exp_adds);
        check_value({tag, "_shifts"}, shifts, exp_shifts);
        check_value({tag, "_sc_trace_errs"}, sc_bad, 0);
        check_value({tag, "_add_then_shift_errs"}, adjacency_bad, 0);
        @(negedge clk);
        check_value({tag, "_y_after"}, y, Y_IDLE);
        check_value({tag, "_done_single"}, done, 0);
        check_value({tag, "_sc_after"}, sc, 0);
        qa_zero = 1'b0; qb_zero = 1'b0; q0 = 1'b0;
    endtask

    initial begin
        int   done_edge;
        int   load2_edge;
        int   ld_before_done;
        int   gap_busy;
        logic seen_add;
        n_checks = 0; n_fail = 0;
        resest = 1'b0; start = 1'b0; qa_zero = 1'b0; qb_zero = 1'b0; q0 = 1'b0;

        // Reset state
        #12;
        check_value("rst_y", y, Y_IDLE);
        check_value("rst_sc", sc, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_strobes", {ld, add_en, shift_en, done}, 0);
        @(negedge clk);
        resest = 1'b1;

        run_op("zeros", 8'h00, 1'b0, 1'b0, 18, 0, 8, 0);
        run_op("m8d", 8'h8D, 1'b0, 1'b0, 22, 4, 8, 0);
        run_op("mff", 8'hFF, 1'b0, 1'b0, 26, 8, 8, 0);
`ifdef MUL_EARLY_EXIT_EN
        run_op("qb_zero", 8'h00, 1'b0, 1'b1, 2, 0, 0, 8);
        run_op("qa_zero", 8'h8D, 1'b1, 1'b0, 2, 0, 0, 8);
`else
        run_op("qb_zero", 8'h00, 1'b0, 1'b1, 18, 0, 8, 0);
        run_op("qa_zero", 8'h8D, 1'b1, 1'b0, 22, 4, 8, 0);
`endif

        // Asynchronous reset in the middle of S_ADD
        @(negedge clk);
        start = 1'b1; q0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen_add = 1'b0;
        for (int e = 0; e < 10 && !seen_add; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (add_en) seen_add = 1'b1;
        end
        check_value("midadd_reached", seen_add, 1);
        resest = 1'b0;
        #1;
        check_value("midadd_rst_y", y, Y_IDLE);
        check_value("midadd_rst_sc", sc, 0);
        check_value("midadd_rst_busy", busy, 0);
        check_value("midadd_rst_add_en", add_en, 0);
        @(negedge clk);
        resest = 1'b1; start = 1'b1; q0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_value("post_rst_y_load", y, Y_LOAD);
        check_value("post_rst_ld", ld, 1);
        resest = 1'b0;
        @(negedge clk);
        resest = 1'b1;

        // start held high for the whole operation and across S_DONE
        done_edge = -1; load2_edge = -1; ld_before_done = 0; gap_busy = 1;
        @(negedge clk);
        start = 1'b1; q0 = 1'b0;
        for (int e = 0; e < 22; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (ld && done_edge < 0) ld_before_done++;
            if (done && done_edge < 0) done_edge = e;
            if (done_edge >= 0 && e == done_edge + 1) gap_busy = busy;
            if (ld && done_edge >= 0 && load2_edge < 0) load2_edge = e;
        end
        start = 1'b0;
        check_value("hold_done_edge", done_edge, 18);
        check_value("hold_ld_count", ld_before_done, 1);
        check_value("hold_idle_gap_busy", gap_busy, 0);
        check_value("hold_load2_edge", load2_edge, 20);
        resest = 1'b0;
        @(negedge clk);
        resest = 1'b1;

        // Illegal state deposit
        @(negedge clk);
        dut.state_q = 7'b0000011;
        dut.sc_q = 4'd5;
        @(posedge clk);
        @(negedge clk);
        check_value("illegal_y", y, Y_IDLE);
        check_value("illegal_sc", sc, 0);
        check_value("illegal_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_controller.md
Name: mul_seq_controller

Overview:
- One-hot sequence controller for a shift-add multiplier datapath.
- Parametrised successor to the team's fixed 8-state timing controller: operand width is a parameter, an internal sequence counter (SC) replaces hard-wired iteration, and the block adds a start/done handshake with a busy flag.
- Drives the load, add and shift strobes of the multiplier datapath and exports the one-hot state for debug.

Parameters:
- WIDTH, 8, operand width in bits; number of add/shift iterations (>=2).
- SC_W, 4, sequence-counter width; must satisfy 2**SC_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resest  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a multiplication; sampled only in S_IDLE.
- qa_zero  input  1  multiplicand register is zero; sampled in S_CHECK.
- qb_zero  input  1  multiplier register is zero; sampled in S_CHECK.
- q0  input  1  current multiplier LSB; sampled in S_TEST.
- y  output  7  one-hot state vector.
- ld  output  1  load operands and clear accumulator.
- add_en  output  1  accumulator <= accumulator + multiplicand.
- shift_en  output  1  shift {E,A,Q} right by one.
- busy  output  1  high in every state except S_IDLE.
- done  output  1  one-cycle pulse; the product is valid.
- sc  output  SC_W  remaining-iteration count.

Behaviour:
- One-hot state encoding: S_IDLE=7'b0000001, S_LOAD=0000010, S_CHECK=0000100, S_TEST=0001000, S_ADD=0010000, S_SHIFT=0100000, S_DONE=1000000.
- All outputs are Moore outputs decoded from the state register (no input-to-output combinational paths): ld=S_LOAD, add_en=S_ADD, shift_en=S_SHIFT, done=S_DONE, busy=~S_IDLE, y=state.
- Reset (resest=0, asynchronous, any time including mid-operation):
  - state=S_IDLE, sc=0.
  - Outputs then read y=7'b0000001, ld=add_en=shift_en=done=busy=0.
  - After release, the first edge is evaluated as S_IDLE.
- Transitions:
  - S_IDLE: start=1 -> S_LOAD, else stay. start is ignored in every other state; there is no queuing.
  - S_LOAD: sc<=WIDTH -> S_CHECK.
  - S_CHECK: (qa_zero|qb_zero) -> S_DONE (early exit, subject to the Optional Feature); else -> S_TEST.
  - S_TEST: q0=1 -> S_ADD; else -> S_SHIFT.
  - S_ADD: -> S_SHIFT.
  - S_SHIFT: sc<=sc-1. If sc==1 (last iteration) -> S_DONE; else -> S_TEST.
  - S_DONE: -> S_IDLE unconditionally. done is high for exactly one cycle.
  - Any non-one-hot or undefined state value -> S_IDLE on the next edge, with sc<=0.
- sc:
  - Holds its value except in S_LOAD (load WIDTH) and S_SHIFT (decrement).
  - Never wraps; the decrement from 1 coincides with the exit to S_DONE, so sc=0 in S_DONE and S_IDLE.
- Latency, counted in edges after the edge that samples start=1:
  - S_DONE is entered after 2 + sum over bits of (2 if bit=0, 3 if bit=1) edges.
  - Minimum: 2+2*WIDTH. Maximum: 2+3*WIDTH.
  - Early exit: S_DONE entered after 2 edges.
- start held high through S_DONE: the block returns to S_IDLE, then accepts a new start on the following edge. The minimum gap between done pulses is 1 idle cycle.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: S_CHECK takes the zero-operand early exit to S_DONE, skipping all iterations; sc stays at WIDTH in S_DONE and is cleared to 0 on entry to S_IDLE.
- Undefined: qa_zero and qb_zero are ignored and S_CHECK always goes to S_TEST, so latency depends only on the multiplier bit pattern.

Test Plan:
- Reset: assert resest=0 mid-S_ADD -> the same cycle shows y=7'b0000001, sc=0, busy=0, add_en=0; after release, start=1 gives S_LOAD on the next edge.
- WIDTH=8, q0 sequence 0,0,0,0,0,0,0,0 -> 8 shift_en pulses, 0 add_en pulses; done asserted 18 edges after start is sampled; sc counts 8..1, then 0.
- WIDTH=8, q0 sequence 1,0,1,1,0,0,0,1 (multiplier 0x8D) -> 4 add_en pulses, each directly followed by shift_en; done after 22 edges; exactly one done pulse.
- MUL_EARLY_EXIT_EN defined, qb_zero=1 at S_CHECK -> S_DONE 2 edges after start, no add_en/shift_en. Undefined, same stimulus with all q0=0 -> done after 18 edges.
- start toggled high during busy, and held high across S_DONE -> no restart mid-operation; the second operation's S_LOAD appears exactly 2 edges after S_DONE.
- Force state to 7'b0000011 via bench deposit -> S_IDLE, sc=0 on the next edge.
